config_loader: RTL and testbench
================================

// Module: config_loader
// PURPOSE
//  Sequences the serial configuration chain of the DPGA fabric. Accepts parallel
//  config words over a valid/ready handshake, serializes each one LSB-first onto
//  sdi_out with a qualifying shift_en, and pulses cfg_latch after the last word.
//  Sits between the host/config port and the shift_register chain.
// PARAMETERS
//  WORD       8  bits per config word; equals the downstream shift_register WORD
//  NUM_WORDS  4  words per full configuration load (>=1)
//  BCNT_W     $clog2(WORD+1)       bit-counter width (derived, localparam)
//  WCNT_W     $clog2(NUM_WORDS+1)  word-counter width (derived, localparam)
// PORTS
//  clk         in   1     system clock, all logic on rising edge
//  reset       in   1     asynchronous, active-low reset
//  start       in   1     begin a load; sampled only in IDLE or DONE
//  abort       in   1     synchronous cancel; returns to IDLE, no latch pulse
//  word_in     in   WORD  config word, valid while word_valid=1
//  word_valid  in   1     word_in valid
//  word_ready  out  1     controller accepts word_in this cycle
//  sdi_out     out  1     serial data to the chain's sdi
//  shift_en    out  1     chain shifts on the next clk edge when 1
//  cfg_latch   out  1     one-cycle pulse: chain contents complete
//  busy        out  1     load in progress (WAIT_WORD, SHIFT, LATCH)
//  done        out  1     last load completed; held until the next start/abort
// BEHAVIOUR
//  - Reset (reset=0): state=IDLE, counters=0, hold=0. All outputs 0.
//  - FSM states: IDLE, WAIT_WORD, SHIFT, LATCH, DONE. State is registered.
//  - All outputs decode from registered state/hold/counters. No input->output
//    combinational path.
//  - IDLE: start=1 -> WAIT_WORD, word_cnt=0.
//  - WAIT_WORD: word_ready=1. Transfer occurs when word_valid & word_ready:
//    hold<=word_in, bit_cnt<=0, next state SHIFT. With no transfer, remain in
//    WAIT_WORD indefinitely.
//  - SHIFT: shift_en=1, sdi_out=hold[0]. Each cycle: hold>>=1, bit_cnt++.
//    When bit_cnt==WORD-1: word_cnt++. Then go to LATCH if
//    word_cnt==NUM_WORDS-1, else to WAIT_WORD. Exactly WORD shift_en cycles
//    per word.
//  - LATCH: cfg_latch=1 for exactly one cycle -> DONE.
//  - DONE: done=1. start=1 -> WAIT_WORD (done clears, word_cnt=0).
//  - Outside SHIFT: shift_en=0 and sdi_out=0. Outside WAIT_WORD: word_ready=0.
//  - word_valid outside WAIT_WORD is ignored; the word is not consumed.
//  - start is ignored while busy=1.
//  - abort=1 in any state -> IDLE next cycle. Counters clear, done=0, no
//    cfg_latch. abort has priority over start and over a handshake in the
//    same cycle.
//  - Timing: with word_valid held high, a load is start + NUM_WORDS*(WORD+1)
//    cycles + 1 LATCH cycle. done rises the cycle after cfg_latch.
//  - reset asserted mid-load: immediate return to reset values. A partially
//    shifted chain is not latched.
// TESTING
//  1. Reset: reset=0 with random inputs -> all outputs 0. After release, state
//     stays IDLE until start.
//  2. WORD=8, NUM_WORDS=2, words 0xA5 then 0x3C, word_valid=1 always
//     -> sdi_out 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0.
//     shift_en high for 2x8 cycles, with a 1-cycle gap for the 2nd handshake.
//     Single cfg_latch pulse after bit 16; done=1 the following cycle.
//  3. Stalled source: word_valid low 5 cycles between words -> word_ready stays
//     high, shift_en stays 0 through the stall, bit stream identical to test 2.
//  4. abort asserted at the 4th shift cycle of word 1 -> IDLE next cycle,
//     shift_en=0, no cfg_latch, done=0. A new start then loads cleanly.
//  5. start pulsed during SHIFT -> ignored, load completes normally. start in
//     DONE -> new load, done clears.
//  6. reset pulsed low mid-SHIFT -> outputs 0 asynchronously, no cfg_latch.
//     Next load after release is correct.

Source files
------------

// File: rtl/config_loader.sv
// Configuration chain sequencer: accepts parallel config words over valid/ready,
// shifts each one out LSB-first with shift_en, then pulses cfg_latch once per load.
module config_loader #(
    parameter int unsigned WORD      = 8,
    parameter int unsigned NUM_WORDS = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic [WORD-1:0] word_in,
    input  logic            word_valid,
    output logic            word_ready,
    output logic            sdi_out,
    output logic            shift_en,
    output logic            cfg_latch,
    output logic            busy,
    output logic            done
);

    localparam int unsigned BCNT_W = $clog2(WORD + 1);
    localparam int unsigned WCNT_W = $clog2(NUM_WORDS + 1);

    typedef enum logic [2:0] {
        StIdle,
        StWaitWord,
        StShift,
        StLatch,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [WORD-1:0]     hold_q, hold_d;
    logic [BCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d    = StWaitWord;
                    word_cnt_d = '0;
                end
            end
            StWaitWord: begin
                if (word_valid) begin
                    hold_d    = word_in;
                    bit_cnt_d = '0;
                    state_d   = StShift;
                end
            end
            StShift: begin
                hold_d    = hold_q >> 1;
                bit_cnt_d = bit_cnt_q + BCNT_W'(1);
                if (bit_cnt_q == BCNT_W'(WORD - 1)) begin
                    word_cnt_d = word_cnt_q + WCNT_W'(1);
                    state_d    = (word_cnt_q == WCNT_W'(NUM_WORDS - 1)) ? StLatch : StWaitWord;
                end
            end
            StLatch: begin
                state_d = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // abort wins over start and over a same-cycle handshake
        if (abort) begin
            state_d    = StIdle;
            hold_d     = '0;
            bit_cnt_d  = '0;
            word_cnt_d = '0;
        end
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            hold_q     <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            word_ready <= 1'b0;
            sdi_out    <= 1'b0;
            shift_en   <= 1'b0;
            cfg_latch  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            word_ready <= (state_d == StWaitWord);
            sdi_out    <= (state_d == StShift) && hold_d[0];
            shift_en   <= (state_d == StShift);
            cfg_latch  <= (state_d == StLatch);
            busy       <= (state_d == StWaitWord) || (state_d == StShift) ||
                          (state_d == StLatch);
            done       <= (state_d == StDone);
        end
    end

endmodule

// File: tb/tb_config_loader.sv
// Self-checking bench for config_loader: expected serial bits are queued at each
// handshake and popped by a monitor whenever shift_en is high.
module tb_config_loader;

    localparam int unsigned WORD      = 8;
    localparam int unsigned NUM_WORDS = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            abort;
    logic [WORD-1:0] word_in;
    logic            word_valid;
    logic            word_ready;
    logic            sdi_out;
    logic            shift_en;
    logic            cfg_latch;
    logic            busy;
    logic            done;

    int checks = 0;
    int errors = 0;
    int latch_cnt = 0;
    bit exp_q[$];

    config_loader #(
        .WORD      (WORD),
        .NUM_WORDS (NUM_WORDS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .sdi_out    (sdi_out),
        .shift_en   (shift_en),
        .cfg_latch  (cfg_latch),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Scoreboard consumer: every shift cycle must carry the next queued bit.
    always @(negedge clk) begin
        bit e;
        if (reset) begin
            if (cfg_latch) latch_cnt++;
            if (shift_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sdi_extra: shift_en=1 sdi_out=%0b, required no shift", sdi_out);
                end else begin
                    e = exp_q.pop_front();
                    if (sdi_out !== e) begin
                        errors++;
                        $display("FAIL sdi_bit: sdi_out=%0b required %0b at %0t", sdi_out, e, $time);
                    end
                end
            end
        end
    end

    task automatic push_word(input logic [WORD-1:0] w);
        for (int i = 0; i < WORD; i++) exp_q.push_back(w[i]);
    endtask

    // Full two-word load with cycle-exact checks; optional source stall and stray start.
    task automatic do_load(input logic [WORD-1:0] w0, input logic [WORD-1:0] w1,
                           input int stall, input bit poke_start);
        int lc0;
        lc0 = latch_cnt;
        @(negedge clk);
        start = 1'b1; word_valid = (stall == 0); word_in = w0;
        @(negedge clk);
        start = 1'b0; word_valid = 1'b1; word_in = w0;
        checks++;
        if (word_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || shift_en !== 1'b0) begin
            errors++;
            $display("FAIL load_start: ready=%0b busy=%0b done=%0b shift_en=%0b, required 1 1 0 0",
                     word_ready, busy, done, shift_en);
        end
        push_word(w0);
        @(negedge clk);
        word_in = w1;
        if (stall != 0) word_valid = 1'b0;
        for (int i = 0; i < WORD; i++) begin
            checks++;
            if (shift_en !== 1'b1 || word_ready !== 1'b0) begin
                errors++;
                $display("FAIL shift_w0[%0d]: shift_en=%0b ready=%0b, required 1 0",
                         i, shift_en, word_ready);
            end
            start = poke_start && (i == 2);
            @(negedge clk);
        end
        start = 1'b0;
        for (int s = 0; s < stall; s++) begin
            checks++;
            if (word_ready !== 1'b1 || shift_en !== 1'b0) begin
                errors++;
                $display("FAIL stall[%0d]: ready=%0b shift_en=%0b, required 1 0",
                         s, word_ready, shift_en);
            end
            @(negedge clk);
        end
        word_valid = 1'b1;
        checks++;
        if (word_ready !== 1'b1 || shift_en !== 1'b0) begin
            errors++;
            $display("FAIL gap: ready=%0b shift_en=%0b, required 1 0", word_ready, shift_en);
        end
        push_word(w1);
        @(negedge clk);
        word_valid = 1'b0;
        for (int i = 0; i < WORD; i++) begin
            checks++;
            if (shift_en !== 1'b1 || cfg_latch !== 1'b0) begin
                errors++;
                $display("FAIL shift_w1[%0d]: shift_en=%0b latch=%0b, required 1 0",
                         i, shift_en, cfg_latch);
            end
            @(negedge clk);
        end
        checks++;
        if (cfg_latch !== 1'b1 || shift_en !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL latch: latch=%0b shift_en=%0b busy=%0b done=%0b, required 1 0 1 0",
                     cfg_latch, shift_en, busy, done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || cfg_latch !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done: done=%0b latch=%0b busy=%0b, required 1 0 0",
                     done, cfg_latch, busy);
        end
        checks++;
        if (latch_cnt != lc0 + 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL latch_count: pulses=%0d left_bits=%0d, required 1 0",
                     latch_cnt - lc0, exp_q.size());
        end
    endtask

    task automatic check_idle(input string name, input int lc0);
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({word_ready, sdi_out, shift_en, cfg_latch, busy, done} !== 6'b0 ||
                latch_cnt != lc0) begin
                errors++;
                $display("FAIL %s: outputs=%b pulses=%0d, required 000000 0", name,
                         {word_ready, sdi_out, shift_en, cfg_latch, busy, done}, latch_cnt - lc0);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; word_valid = 1'b0; word_in = '0;
        #2 reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            start = 1'($urandom); abort = 1'($urandom);
            word_valid = 1'($urandom); word_in = WORD'($urandom);
            #1;
            checks++;
            if ({word_ready, sdi_out, shift_en, cfg_latch, busy, done} !== 6'b0) begin
                errors++;
                $display("FAIL reset_outputs: outputs=%b, required 000000",
                         {word_ready, sdi_out, shift_en, cfg_latch, busy, done});
            end
        end
        @(negedge clk);
        reset = 1'b1; start = 1'b0; abort = 1'b0; word_valid = 1'b1; word_in = 8'hFF;
        check_idle("post_reset_idle", latch_cnt);
        word_valid = 1'b0;
    endtask

    task automatic test_basic();
        do_load(8'hA5, 8'h3C, 0, 1'b0);
    endtask

    task automatic test_stall();
        do_load(8'hA5, 8'h3C, 5, 1'b0);
    endtask

    task automatic test_abort();
        int lc0;
        lc0 = latch_cnt;
        @(negedge clk);
        start = 1'b1; word_valid = 1'b1; word_in = 8'h96;
        @(negedge clk);
        start = 1'b0;
        push_word(8'h96);
        @(negedge clk);
        word_valid = 1'b0;
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        exp_q.delete();
        checks++;
        if ({word_ready, shift_en, cfg_latch, busy, done} !== 5'b0) begin
            errors++;
            $display("FAIL abort_idle: ready/shift/latch/busy/done=%b, required 00000",
                     {word_ready, shift_en, cfg_latch, busy, done});
        end
        check_idle("abort_no_latch", lc0);
        do_load(8'h5A, 8'hC3, 0, 1'b0);
    endtask

    task automatic test_start_ignored();
        do_load(8'h81, 8'h7E, 0, 1'b1);
        do_load(8'h0F, 8'hF0, 0, 1'b0);
    endtask

    task automatic test_reset_mid_shift();
        int lc0;
        lc0 = latch_cnt;
        @(negedge clk);
        start = 1'b1; word_valid = 1'b1; word_in = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        push_word(8'hFF);
        @(negedge clk);
        word_valid = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        exp_q.delete();
        checks++;
        if ({word_ready, sdi_out, shift_en, cfg_latch, busy, done} !== 6'b0) begin
            errors++;
            $display("FAIL reset_async: outputs=%b, required 000000",
                     {word_ready, sdi_out, shift_en, cfg_latch, busy, done});
        end
        @(negedge clk);
        reset = 1'b1;
        check_idle("reset_no_latch", lc0);
        do_load(8'h33, 8'hC6, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_abort();
        test_start_ignored();
        test_reset_mid_shift();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
